// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: receives a length/data/checksum byte frame and writes instruction memory
// Holds the CPU in reset until a complete frame with a matching checksum has been stored.
module prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam int          IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t              state_q;
    logic [7:0]          len_hi_q;
    logic [ADDR_W-1:0]   last_idx_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [1:0]          byte_cnt_q;
    logic [23:0]         asm_q;
    logic [7:0]          sum_q;
    logic [IDLE_W-1:0]   idle_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                cpu_rst_q;
    logic                load_done_q;
    logic                load_err_q;

    logic [15:0]         len_d;
    logic                len_ok_d;
    logic [31:0]         asm_d;
    logic [7:0]          sum_d;
    logic                timeout_d;
    logic                active_d;

    assign len_d     = {len_hi_q, rx_data};
    assign len_ok_d  = (len_d != 16'd0) && ({1'b0, len_d} <= MAX_WORDS);
    assign asm_d     = {asm_q, rx_data};
    assign sum_d     = sum_q + rx_data;
    assign active_d  = (state_q == S_LEN_LO) || (state_q == S_DATA) || (state_q == S_CSUM);
    // Fires on the TIMEOUT-th consecutive idle edge after the last accepted byte.
    assign timeout_d = active_d && !rx_valid && (idle_q == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LEN_HI;
            len_hi_q     <= 8'd0;
            last_idx_q   <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 24'd0;
            sum_q        <= 8'd0;
            idle_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_rst_q    <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;

            if (active_d) begin
                if (rx_valid) begin
                    idle_q <= '0;
                end else begin
                    idle_q <= idle_q + 1'b1;
                end
            end

            if (timeout_d) begin
                state_q    <= S_ERR;
                load_err_q <= 1'b1;
            end else begin
                case (state_q)
                    S_LEN_HI: begin
                        if (rx_valid) begin
                            len_hi_q <= rx_data;
                            state_q  <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        if (rx_valid) begin
                            if (len_ok_d) begin
                                last_idx_q <= ADDR_W'(len_d - 16'd1);
                                state_q    <= S_DATA;
                            end else begin
                                state_q    <= S_ERR;
                                load_err_q <= 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            asm_q      <= asm_d[23:0];
                            sum_q      <= sum_d;
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                imem_we_q    <= 1'b1;
                                imem_wdata_q <= asm_d;
                                imem_addr_q  <= word_idx_q;
                                word_idx_q   <= word_idx_q + 1'b1;
                                // Leave immediately so a checksum byte landing on the write pulse is taken.
                                if (word_idx_q == last_idx_q) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        end
                    end
                    S_CSUM: begin
                        if (rx_valid) begin
                            if (rx_data == sum_q) begin
                                state_q     <= S_RUN;
                                cpu_rst_q   <= 1'b0;
                                load_done_q <= 1'b1;
                            end else begin
                                state_q    <= S_ERR;
                                load_err_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;

    int          checks;
    int          errors;
    int          wr_count;
    int          base;
    logic [9:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic [7:0]  frame [$];

    prog_loader #(.ADDR_W(10), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial wr_count = 0;
    always @(posedge clk) begin
        #1;
        if (imem_we === 1'b1) begin
            if (wr_count < 64) begin
                wr_addr[wr_count] = imem_addr;
                wr_data[wr_count] = imem_wdata;
            end
            wr_count = wr_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input bit b2b);
        for (int i = 0; i < frame.size(); i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = frame[i];
            if (!b2b) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        if (b2b) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        rst = 1'b0;

        // single-word frame with gaps
        base  = wr_count;
        frame = '{8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h05, 8'h31};
        send_frame(1'b0);
        check("f1_wr_count", 32'(wr_count - base), 32'd1);
        check("f1_addr", 32'(wr_addr[base]), 32'd0);
        check("f1_data", wr_data[base], 32'h24080005);
        check("f1_done", 32'(load_done), 32'd1);
        check("f1_cpu_rst", 32'(cpu_rst), 32'd0);
        check("f1_err", 32'(load_err), 32'd0);
        frame = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(1'b1);
        repeat (3) @(negedge clk);
        check("run_ignore_wr", 32'(wr_count - base), 32'd1);
        check("run_hold_done", 32'(load_done), 32'd1);
        check("run_hold_wdata", imem_wdata, 32'h24080005);
        check("run_hold_addr", 32'(imem_addr), 32'd0);

        // two words, back to back so bytes coincide with write pulses
        do_reset();
        base  = wr_count;
        frame = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h45};
        send_frame(1'b1);
        check("f2_wr_count", 32'(wr_count - base), 32'd2);
        check("f2_addr0", 32'(wr_addr[base]), 32'd0);
        check("f2_data0", wr_data[base], 32'h3C010000);
        check("f2_addr1", 32'(wr_addr[base + 1]), 32'd1);
        check("f2_data1", wr_data[base + 1], 32'h00000008);
        check("f2_done", 32'(load_done), 32'd1);

        // bad checksum
        do_reset();
        base  = wr_count;
        frame = '{8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h05, 8'h32};
        send_frame(1'b0);
        check("bad_cs_wr", 32'(wr_count - base), 32'd1);
        check("bad_cs_err", 32'(load_err), 32'd1);
        check("bad_cs_cpu_rst", 32'(cpu_rst), 32'd1);
        check("bad_cs_done", 32'(load_done), 32'd0);

        // length bounds
        do_reset();
        base  = wr_count;
        frame = '{8'h00, 8'h00};
        send_frame(1'b0);
        check("len0_err", 32'(load_err), 32'd1);
        do_reset();
        frame = '{8'h04, 8'h01};
        send_frame(1'b0);
        check("len1025_err", 32'(load_err), 32'd1);
        check("len_bad_no_wr", 32'(wr_count - base), 32'd0);
        do_reset();
        frame = '{8'h04, 8'h00};
        send_frame(1'b0);
        check("len1024_ok", 32'(load_err), 32'd0);

        // idle in S_LEN_HI never times out; stall mid-data does
        do_reset();
        repeat (100) @(negedge clk);
        check("idle_hi_err", 32'(load_err), 32'd0);
        check("idle_hi_cpu_rst", 32'(cpu_rst), 32'd1);
        base  = wr_count;
        frame = '{8'h00, 8'h01, 8'h24, 8'h08};
        send_frame(1'b0);
        repeat (15) @(negedge clk);
        check("tmo_15_err", 32'(load_err), 32'd0);
        @(negedge clk);
        check("tmo_16_err", 32'(load_err), 32'd1);
        check("tmo_done", 32'(load_done), 32'd0);
        check("tmo_no_wr", 32'(wr_count - base), 32'd0);

        // reset mid-frame, then a fresh frame starts at address 0
        do_reset();
        base  = wr_count;
        frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
        send_frame(1'b0);
        do_reset();
        frame = '{8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h05, 8'h31};
        send_frame(1'b0);
        check("abort_wr_count", 32'(wr_count - base), 32'd1);
        check("abort_addr", 32'(wr_addr[base]), 32'd0);
        check("abort_data", wr_data[base], 32'h24080005);
        check("abort_done", 32'(load_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
